// File: rtl/id_operand_stage.sv
// RV32I decode/operand-collect stage between IF and EX: holds one instruction, resolves
// rs1/rs2 through prioritised forwarding and a write-through register file, and resolves B/JAL/JALR.
module id_operand_stage #(
    parameter int NFWD   = 3,
    parameter bit BR_FWD = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_to_id_valid,
    input  logic [31:0]         if_inst,
    input  logic [31:0]         if_pc,
    output logic                id_allowin,
    input  logic                ex_allowin,
    output logic                id_to_ex_valid,
    output logic [31:0]         id_inst,
    output logic [31:0]         id_pc,
    output logic [31:0]         rs1_value,
    output logic [31:0]         rs2_value,
    input  logic                flush,
    input  logic [NFWD-1:0]     fwd_addr_valid,
    input  logic [NFWD-1:0]     fwd_data_valid,
    input  logic [5*NFWD-1:0]   fwd_addr,
    input  logic [32*NFWD-1:0]  fwd_data,
    input  logic                rf_wen,
    input  logic [4:0]          rf_waddr,
    input  logic [31:0]         rf_wdata,
    output logic                bj_valid,
    output logic                bj_taken,
    output logic [31:0]         bj_target,
    output logic [CNT_W-1:0]    stall_cnt
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic              id_valid;
    logic [31:0]       inst_q;
    logic [31:0]       pc_q;
    logic [31:0]       rf [1:31];
    logic [CNT_W-1:0]  stall_q;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_b, is_jal, is_jalr;
    logic              use_rs1, use_rs2;
    logic [1:0][4:0]   rs_addr;
    logic [1:0][31:0]  rs_val;
    logic [1:0]        rs_hit, rs_wait;
    logic              stall, ready_go, fire;
    logic              cmp_true;
    logic [31:0]       imm_i, imm_b, imm_j;

    assign opcode  = inst_q[6:0];
    assign funct3  = inst_q[14:12];
    assign rs_addr = {inst_q[24:20], inst_q[19:15]};
    assign is_b    = (opcode == OP_B);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign use_rs1 = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                     is_jalr || (opcode == OP_STORE) || is_b;
    assign use_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || is_b;

    assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

    // Scanning from the oldest source down lets the youngest match overwrite the rest.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rs_val  = '0;
        rs_hit  = '0;
        rs_wait = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (fwd_addr_valid[i] && (fwd_addr[5*i +: 5] == rs_addr[k]) && (rs_addr[k] != 5'd0)) begin
                    rs_hit[k]  = 1'b1;
                    rs_wait[k] = ~fwd_data_valid[i];
                    rs_val[k]  = fwd_data[32*i +: 32];
                end
            end
            if (!rs_hit[k] && (rs_addr[k] != 5'd0)) begin
                rs_val[k] = (rf_wen && (rf_waddr == rs_addr[k])) ? rf_wdata : rf[rs_addr[k]];
            end
        end
    end

    always_comb begin
        stall = (use_rs1 && rs_wait[0]) || (use_rs2 && rs_wait[1]);
        if (!BR_FWD && is_b && ((use_rs1 && rs_hit[0]) || (use_rs2 && rs_hit[1]))) begin
            stall = 1'b1;
        end
    end

    assign ready_go       = ~stall;
    assign id_allowin     = ~id_valid | (ready_go & ex_allowin);
    assign fire           = id_valid & ready_go & ex_allowin & ~flush;
    assign id_to_ex_valid = id_valid & ready_go & ~flush;
    assign id_inst        = inst_q;
    assign id_pc          = pc_q;
    assign rs1_value      = use_rs1 ? rs_val[0] : 32'd0;
    assign rs2_value      = use_rs2 ? rs_val[1] : 32'd0;
    assign stall_cnt      = stall_q;

    always_comb begin
        cmp_true = 1'b0;
        case (funct3)
            3'b000:  cmp_true = (rs_val[0] == rs_val[1]);
            3'b001:  cmp_true = (rs_val[0] != rs_val[1]);
            3'b100:  cmp_true = ($signed(rs_val[0]) <  $signed(rs_val[1]));
            3'b101:  cmp_true = ($signed(rs_val[0]) >= $signed(rs_val[1]));
            3'b110:  cmp_true = (rs_val[0] <  rs_val[1]);
            3'b111:  cmp_true = (rs_val[0] >= rs_val[1]);
            default: cmp_true = 1'b0;
        endcase
    end

    always_comb begin
        bj_target = 32'd0;
        if (is_b)         bj_target = pc_q + imm_b;
        else if (is_jal)  bj_target = pc_q + imm_j;
        else if (is_jalr) bj_target = (rs_val[0] + imm_i) & 32'hFFFF_FFFE;
    end

    assign bj_valid = fire & (is_b | is_jal | is_jalr);
    assign bj_taken = bj_valid & (is_jal | is_jalr | cmp_true);

    // A flush wins over a same-cycle capture, so the presented instruction is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            id_valid <= 1'b0;
            inst_q   <= 32'd0;
            pc_q     <= 32'd0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (id_allowin) begin
            id_valid <= if_to_id_valid;
            if (if_to_id_valid) begin
                inst_q <= if_inst;
                pc_q   <= if_pc;
            end
        end
    end

    // NOTE: the register file must clear on reset, so it is built from flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) rf[r] <= 32'd0;
        end else if (rf_wen && (rf_waddr != 5'd0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (id_valid && !ready_go && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: two instances (BR_FWD=1/CNT_W=16 and BR_FWD=0/CNT_W=3) share stimulus;
// directed scenarios use hand-derived constants, a random phase uses a behavioural model.
module tb_id_operand_stage;
    localparam int NFWD = 3;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_JALR = 7'b1100111, OP_S = 7'b0100011, OP_B = 7'b1100011,
                           OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_to_id_valid, ex_allowin, flush, rf_wen;
    logic [31:0] if_inst, if_pc, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        f_av [NFWD];
    logic        f_dv [NFWD];
    logic [4:0]  f_a  [NFWD];
    logic [31:0] f_d  [NFWD];
    logic [NFWD-1:0]    fwd_addr_valid, fwd_data_valid;
    logic [5*NFWD-1:0]  fwd_addr;
    logic [32*NFWD-1:0] fwd_data;

    for (genvar g = 0; g < NFWD; g++) begin : g_pack
        assign fwd_addr_valid[g]     = f_av[g];
        assign fwd_data_valid[g]     = f_dv[g];
        assign fwd_addr[5*g +: 5]    = f_a[g];
        assign fwd_data[32*g +: 32]  = f_d[g];
    end

    logic        d1_allowin, d1_valid, d1_bjv, d1_bjt, d0_allowin, d0_valid, d0_bjv, d0_bjt;
    logic [31:0] d1_inst, d1_pc, d1_rs1, d1_rs2, d1_tgt, d0_inst, d0_pc, d0_rs1, d0_rs2, d0_tgt;
    logic [15:0] d1_cnt;
    logic [2:0]  d0_cnt;

    id_operand_stage #(.NFWD(NFWD), .BR_FWD(1'b1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .if_to_id_valid(if_to_id_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_allowin(d1_allowin), .ex_allowin(ex_allowin), .id_to_ex_valid(d1_valid),
        .id_inst(d1_inst), .id_pc(d1_pc), .rs1_value(d1_rs1), .rs2_value(d1_rs2), .flush(flush),
        .fwd_addr_valid(fwd_addr_valid), .fwd_data_valid(fwd_data_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .bj_valid(d1_bjv), .bj_taken(d1_bjt), .bj_target(d1_tgt), .stall_cnt(d1_cnt));

    id_operand_stage #(.NFWD(NFWD), .BR_FWD(1'b0), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .if_to_id_valid(if_to_id_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_allowin(d0_allowin), .ex_allowin(ex_allowin), .id_to_ex_valid(d0_valid),
        .id_inst(d0_inst), .id_pc(d0_pc), .rs1_value(d0_rs1), .rs2_value(d0_rs2), .flush(flush),
        .fwd_addr_valid(fwd_addr_valid), .fwd_data_valid(fwd_data_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .bj_valid(d0_bjv), .bj_taken(d0_bjt), .bj_target(d0_tgt), .stall_cnt(d0_cnt));

    // Index 1 = BR_FWD=1 instance, index 0 = BR_FWD=0 instance.
    logic        o_allowin [2], o_valid [2], o_bjv [2], o_bjt [2];
    logic [31:0] o_inst [2], o_pc [2], o_rs1 [2], o_rs2 [2], o_tgt [2];
    logic [15:0] o_cnt [2];
    always_comb begin
        o_allowin[1] = d1_allowin; o_valid[1] = d1_valid; o_bjv[1] = d1_bjv; o_bjt[1] = d1_bjt;
        o_inst[1] = d1_inst; o_pc[1] = d1_pc; o_rs1[1] = d1_rs1; o_rs2[1] = d1_rs2; o_tgt[1] = d1_tgt;
        o_cnt[1] = d1_cnt;
        o_allowin[0] = d0_allowin; o_valid[0] = d0_valid; o_bjv[0] = d0_bjv; o_bjt[0] = d0_bjt;
        o_inst[0] = d0_inst; o_pc[0] = d0_pc; o_rs1[0] = d0_rs1; o_rs2[0] = d0_rs2; o_tgt[0] = d0_tgt;
        o_cnt[0] = {13'd0, d0_cnt};
    end

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic        allowin, valid, stall, bjv, bjt;
        logic [31:0] rs1, rs2, tgt;
    } exp_t;

    logic        m_valid [2];
    logic [31:0] m_inst [2], m_pc [2];
    logic [15:0] m_cnt [2];
    logic [31:0] m_rf [32];

    // {must_wait, value} for one source register
    function automatic logic [32:0] resolve(input logic [4:0] rs);
        if (rs == 5'd0) return 33'd0;
        for (int i = 0; i < NFWD; i++)
            if (f_av[i] && f_a[i] == rs) return {!f_dv[i], f_d[i]};
        if (rf_wen && rf_waddr == rs) return {1'b0, rf_wdata};
        return {1'b0, m_rf[rs]};
    endfunction

    function automatic logic any_match(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        for (int i = 0; i < NFWD; i++) if (f_av[i] && f_a[i] == rs) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        logic [31:0] in, ra, rb, imm;
        logic [6:0]  op;
        logic        u1, u2, t, fire;
        logic [32:0] a, b;
        in = m_inst[v];
        op = in[6:0];
        u1 = op inside {OP_R, OP_I, OP_LOAD, OP_JALR, OP_S, OP_B};
        u2 = op inside {OP_R, OP_S, OP_B};
        a  = resolve(in[19:15]);
        b  = resolve(in[24:20]);
        ra = a[31:0];
        rb = b[31:0];
        e.stall = (u1 && a[32]) || (u2 && b[32]) ||
                  (v == 0 && op == OP_B && (any_match(in[19:15]) || any_match(in[24:20])));
        case (in[14:12])
            3'd0: t = (ra == rb);
            3'd1: t = (ra != rb);
            3'd4: t = ($signed(ra) < $signed(rb));
            3'd5: t = ($signed(ra) >= $signed(rb));
            3'd6: t = (ra < rb);
            3'd7: t = (ra >= rb);
            default: t = 1'b0;
        endcase
        if (op == OP_B) begin
            imm   = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
            e.tgt = m_pc[v] + imm;
        end else if (op == OP_JAL) begin
            imm   = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
            e.tgt = m_pc[v] + imm;
        end else begin
            imm   = {{20{in[31]}}, in[31:20]};
            e.tgt = (ra + imm) & 32'hFFFF_FFFE;
        end
        fire      = m_valid[v] && !e.stall && ex_allowin && !flush;
        e.valid   = m_valid[v] && !e.stall && !flush;
        e.allowin = !m_valid[v] || (!e.stall && ex_allowin);
        e.bjv     = fire && (op inside {OP_B, OP_JAL, OP_JALR});
        e.bjt     = e.bjv && (op != OP_B || t);
        e.rs1     = u1 ? ra : 32'd0;
        e.rs2     = u2 ? rb : 32'd0;
        return e;
    endfunction

    // Advance the model with the inputs as they stand, then move past the next rising edge.
    task automatic tick();
        exp_t e [2];
        e[0] = model(0);
        e[1] = model(1);
        for (int v = 0; v < 2; v++) begin
            if (rst) begin
                m_valid[v] = 1'b0; m_inst[v] = 32'd0; m_pc[v] = 32'd0; m_cnt[v] = 16'd0;
            end else begin
                if (m_valid[v] && e[v].stall && !flush && m_cnt[v] != ((v == 0) ? 16'd7 : 16'hFFFF))
                    m_cnt[v] = m_cnt[v] + 16'd1;
                if (flush) m_valid[v] = 1'b0;
                else if (e[v].allowin) begin
                    m_valid[v] = if_to_id_valid;
                    if (if_to_id_valid) begin m_inst[v] = if_inst; m_pc[v] = if_pc; end
                end
            end
        end
        if (rst) for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
        else if (rf_wen && rf_waddr != 5'd0) m_rf[rf_waddr] = rf_wdata;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_fwd();
        for (int i = 0; i < NFWD; i++) begin
            f_av[i] = 1'b0; f_dv[i] = 1'b0; f_a[i] = 5'd0; f_d[i] = 32'd0;
        end
    endtask

    task automatic set_fwd(input int i, input logic av, input logic dv, input logic [4:0] a,
                           input logic [31:0] d);
        f_av[i] = av; f_dv[i] = dv; f_a[i] = a; f_d[i] = d;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        rf_wen = 1'b1; rf_waddr = a; rf_wdata = d;
        tick();
        rf_wen = 1'b0;
    endtask

    // Empties the stage, then captures one instruction and holds it (ex_allowin=0).
    task automatic load(input logic [31:0] inst, input logic [31:0] pc);
        clear_fwd();
        if_to_id_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; if_to_id_valid = 1'b1; if_inst = inst; if_pc = pc; ex_allowin = 1'b0;
        tick();
        if_to_id_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = OP_R;    1: w[6:0] = OP_I;    2: w[6:0] = OP_LOAD;
            3: w[6:0] = OP_JALR; 4: w[6:0] = OP_S;    5: w[6:0] = OP_B;
            6: w[6:0] = OP_B;    7: w[6:0] = OP_JAL;  8: w[6:0] = 7'b0110111;
            default: w[6:0] = 7'b0010111;
        endcase
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_vec++; if (d1_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin: got %b want 1", d1_allowin); end
        n_vec++; if (d1_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", d1_valid); end
        n_vec++; if ({d1_bjv, d1_bjt} !== 2'b00) begin n_err++; $display("FAIL reset_bj: got %b want 00", {d1_bjv, d1_bjt}); end
        n_vec++; if (d1_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", d1_cnt); end
        n_vec++; if (d0_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt0: got %0d want 0", d0_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        rf_write(5'd5, 32'hDEAD_BEEF);
        load(32'h0002_81B3, 32'h40);           // add x3,x5,x0
        #2;
        n_vec++; if (d1_rs1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL x5_before_rst: got %h want deadbeef", d1_rs1); end
        load(32'h0020_81B3, 32'h44);           // add x3,x1,x2
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'h0);
        ex_allowin = 1'b1;
        repeat (5) tick();
        #2;
        n_vec++; if (d1_cnt !== 16'd5) begin n_err++; $display("FAIL midstall_cnt: got %0d want 5", d1_cnt); end
        n_vec++; if (d1_valid !== 1'b0) begin n_err++; $display("FAIL midstall_valid: got %b want 0", d1_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        n_vec++; if (d1_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", d1_valid); end
        n_vec++; if (d1_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", d1_cnt); end
        load(32'h0002_81B3, 32'h48);
        #2;
        n_vec++; if (d1_rs1 !== 32'd0) begin n_err++; $display("FAIL x5_after_rst: got %h want 0", d1_rs1); end
        n_vec++; if (d1_valid !== 1'b1) begin n_err++; $display("FAIL x5_after_rst_valid: got %b want 1", d1_valid); end
    endtask

    task automatic test_fwd_priority();
        rf_write(5'd2, 32'd7);
        load(32'h0020_81B3, 32'h80);
        set_fwd(0, 1'b1, 1'b1, 5'd1, 32'h11);
        set_fwd(1, 1'b1, 1'b1, 5'd1, 32'h22);
        #2;
        n_vec++; if (d1_rs1 !== 32'h11) begin n_err++; $display("FAIL prio_rs1: got %h want 11", d1_rs1); end
        n_vec++; if (d1_rs2 !== 32'd7) begin n_err++; $display("FAIL prio_rs2: got %h want 7", d1_rs2); end
        n_vec++; if (d1_valid !== 1'b1) begin n_err++; $display("FAIL prio_valid: got %b want 1", d1_valid); end
        f_av[0] = 1'b0;
        #2;
        n_vec++; if (d1_rs1 !== 32'h22) begin n_err++; $display("FAIL prio_fwd1: got %h want 22", d1_rs1); end
        clear_fwd();
        rf_wen = 1'b1; rf_waddr = 5'd2; rf_wdata = 32'h99;
        #2;
        n_vec++; if (d1_rs2 !== 32'h99) begin n_err++; $display("FAIL write_through: got %h want 99", d1_rs2); end
        tick();
        rf_wen = 1'b0;
        #2;
        n_vec++; if (d1_rs2 !== 32'h99) begin n_err++; $display("FAIL rf_landed: got %h want 99", d1_rs2); end
    endtask

    task automatic test_load_use();
        load(32'h0020_81B3, 32'hC0);
        ex_allowin = 1'b1;
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'h0);
        #2;
        n_vec++; if (d1_allowin !== 1'b0) begin n_err++; $display("FAIL lu_allowin: got %b want 0", d1_allowin); end
        n_vec++; if (d1_valid !== 1'b0) begin n_err++; $display("FAIL lu_valid: got %b want 0", d1_valid); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            #2;
            n_vec++; if (d1_cnt !== 16'(k)) begin n_err++; $display("FAIL lu_cnt: got %0d want %0d", d1_cnt, k); end
        end
        f_dv[0] = 1'b1; f_d[0] = 32'h5;
        #2;
        n_vec++; if (d1_rs1 !== 32'h5) begin n_err++; $display("FAIL lu_rs1: got %h want 5", d1_rs1); end
        n_vec++; if (d1_valid !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b want 1", d1_valid); end
        tick();
        #2;
        n_vec++; if (d1_valid !== 1'b0) begin n_err++; $display("FAIL lu_fired: got %b want 0", d1_valid); end
        n_vec++; if (d1_cnt !== 16'd3) begin n_err++; $display("FAIL lu_cnt_hold: got %0d want 3", d1_cnt); end
    endtask

    task automatic test_unused_operand();
        load(32'h1234_50B7, 32'h100);          // lui x1,0x12345
        for (int a = 0; a < 32; a++) begin
            for (int i = 0; i < NFWD; i++) set_fwd(i, 1'b1, 1'b0, 5'(a), 32'hFFFF_FFFF);
            #2;
            n_vec++;
            if ({d1_valid, d1_rs1, d1_rs2} !== {1'b1, 64'd0}) begin
                n_err++; $display("FAIL unused x%0d: got v=%b rs1=%h rs2=%h want v=1 0 0", a, d1_valid, d1_rs1, d1_rs2);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        load(32'h0020_C863, 32'h100);          // blt x1,x2,+16
        ex_allowin = 1'b1;
        set_fwd(0, 1'b1, 1'b1, 5'd1, 32'hFFFF_FFFF);
        set_fwd(1, 1'b1, 1'b1, 5'd2, 32'd1);
        #2;
        n_vec++; if ({d1_bjv, d1_bjt} !== 2'b11) begin n_err++; $display("FAIL br_bj: got %b want 11", {d1_bjv, d1_bjt}); end
        n_vec++; if (d1_tgt !== 32'h110) begin n_err++; $display("FAIL br_target: got %h want 110", d1_tgt); end
        n_vec++; if (d1_valid !== 1'b1) begin n_err++; $display("FAIL br_nostall: got %b want 1", d1_valid); end
        n_vec++; if ({d0_valid, d0_bjv, d0_allowin} !== 3'b000) begin n_err++; $display("FAIL br0_stall: got %b want 000", {d0_valid, d0_bjv, d0_allowin}); end
        tick();
        clear_fwd();
        #2;
        // x1=0 and x2=0x99 from the RF: 0 < 0x99 is taken
        n_vec++; if ({d0_bjv, d0_bjt} !== 2'b11) begin n_err++; $display("FAIL br0_release: got %b want 11", {d0_bjv, d0_bjt}); end
        n_vec++; if (d0_tgt !== 32'h110) begin n_err++; $display("FAIL br0_target: got %h want 110", d0_tgt); end
        n_vec++; if (d1_bjv !== 1'b0) begin n_err++; $display("FAIL br1_gone: got %b want 0", d1_bjv); end
        tick();
    endtask

    task automatic test_flush();
        load(32'h0080_00EF, 32'h200);          // jal x1,+8
        ex_allowin = 1'b1;
        #2;
        n_vec++; if ({d1_bjv, d1_bjt, d1_tgt} !== {2'b11, 32'h208}) begin n_err++; $display("FAIL jal: got %b%b %h want 11 208", d1_bjv, d1_bjt, d1_tgt); end
        flush = 1'b1; if_to_id_valid = 1'b1; if_inst = 32'h0000_0013; if_pc = 32'h204;
        #2;
        n_vec++; if ({d1_bjv, d1_valid} !== 2'b00) begin n_err++; $display("FAIL flush_mask: got %b want 00", {d1_bjv, d1_valid}); end
        tick();
        flush = 1'b0;
        #2;
        n_vec++; if ({d1_valid, d1_allowin} !== 2'b01) begin n_err++; $display("FAIL flush_drop: got %b want 01", {d1_valid, d1_allowin}); end
        if_to_id_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        clear_fwd();
        ex_allowin = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = (32'(k) << 20) | 32'h0000_0093;  // addi x1,x0,k
            if_to_id_valid = 1'b1; if_inst = w; if_pc = 32'h300 + 32'(4 * k);
            tick();
            #2;
            n_vec++; if ({d1_valid, d1_inst} !== {1'b1, w}) begin n_err++; $display("FAIL b2b[%0d]: got %b %h want 1 %h", k, d1_valid, d1_inst, w); end
        end
        if_inst = 32'h0080_00EF; if_pc = 32'h400;
        tick();
        ex_allowin = 1'b0; if_inst = 32'h0000_0013; if_pc = 32'h404;
        #2;
        n_vec++; if ({d1_valid, d1_bjv, d1_allowin} !== 3'b100) begin n_err++; $display("FAIL ex_block: got %b want 100", {d1_valid, d1_bjv, d1_allowin}); end
        tick();
        #2;
        n_vec++; if ({d1_inst, d1_pc} !== {32'h0080_00EF, 32'h400}) begin n_err++; $display("FAIL ex_hold: got %h %h want 008000ef 400", d1_inst, d1_pc); end
        if_to_id_valid = 1'b0;
    endtask

    task automatic test_saturation();
        load(32'h0020_81B3, 32'h500);
        ex_allowin = 1'b1;
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'h0);
        repeat (10) tick();
        #2;
        n_vec++; if (d0_cnt !== 3'd7) begin n_err++; $display("FAIL sat_cnt0: got %0d want 7", d0_cnt); end
        n_vec++; if (d1_cnt !== 16'd13) begin n_err++; $display("FAIL sat_cnt1: got %0d want 13", d1_cnt); end
        clear_fwd();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        for (int c = 0; c < 400; c++) begin
            if_to_id_valid = 1'($urandom_range(0, 1));
            if_inst = rand_inst();
            if_pc = $urandom & 32'hFFFF_FFFC;
            ex_allowin = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NFWD; i++)
                set_fwd(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                        $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)));
            rf_wen = 1'($urandom_range(0, 1));
            rf_waddr = 5'($urandom_range(0, 7));
            rf_wdata = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            #2;
            for (int v = 0; v < 2; v++) begin
                e = model(v);
                n_vec++;
                if ({o_allowin[v], o_valid[v], o_bjv[v], o_bjt[v]} !== {e.allowin, e.valid, e.bjv, e.bjt}) begin
                    n_err++; $display("FAIL rnd_ctrl[%0d] cyc %0d: got %b want %b", v, c,
                        {o_allowin[v], o_valid[v], o_bjv[v], o_bjt[v]}, {e.allowin, e.valid, e.bjv, e.bjt});
                end
                n_vec++;
                if (o_cnt[v] !== m_cnt[v]) begin
                    n_err++; $display("FAIL rnd_cnt[%0d] cyc %0d: got %0d want %0d", v, c, o_cnt[v], m_cnt[v]);
                end
                if (m_valid[v]) begin
                    n_vec++;
                    if ({o_inst[v], o_pc[v], o_rs1[v], o_rs2[v]} !== {m_inst[v], m_pc[v], e.rs1, e.rs2}) begin
                        n_err++; $display("FAIL rnd_ops[%0d] cyc %0d: got %h %h %h %h want %h %h %h %h", v, c,
                            o_inst[v], o_pc[v], o_rs1[v], o_rs2[v], m_inst[v], m_pc[v], e.rs1, e.rs2);
                    end
                end
                if (e.bjv) begin
                    n_vec++;
                    if (o_tgt[v] !== e.tgt) begin
                        n_err++; $display("FAIL rnd_tgt[%0d] cyc %0d: got %h want %h", v, c, o_tgt[v], e.tgt);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; if_to_id_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0; ex_allowin = 1'b0;
        flush = 1'b0; rf_wen = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0;
        clear_fwd();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_reset_mid_stall();
        test_fwd_priority();
        test_load_use();
        test_unused_operand();
        test_branch();
        test_flush();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
